// File: rtl/fpu_pkg.sv
// Shared types for the FPU issue sequencer: opcodes, FSM states, destination decode.
package fpu_pkg;

    typedef enum logic [3:0] {
        OpFadd   = 4'd0,
        OpFsub   = 4'd1,
        OpFmul   = 4'd2,
        OpFdiv   = 4'd3,
        OpFsqrt  = 4'd4,
        OpFsgnj  = 4'd5,
        OpFsgnjn = 4'd6,
        OpFsgnjx = 4'd7,
        OpFeq    = 4'd8,
        OpFle    = 4'd9,
        OpFlt    = 4'd10,
        OpNop    = 4'hF
    } fpu_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StWb
    } fpu_issue_state_t;

    // Compares produce a 0/1 that belongs in the integer register file.
    function automatic logic is_int_dest(input logic [3:0] op);
        return (op >= 4'(OpFeq)) && (op <= 4'(OpFlt));
    endfunction

endpackage

// File: rtl/fpu_issue_if.sv
// Decode request, FPU operand/result and writeback signals of the FPU issue block.
interface fpu_issue_if;

    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_src0;
    logic [31:0] req_src1;
    logic [4:0]  req_rd;
    logic [31:0] fpu_src0;
    logic [31:0] fpu_src1;
    logic [3:0]  fpu_op;
    logic [31:0] fpu_result;
    logic        fpu_fin;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_int;
    logic        busy;
    logic        err;

    modport slave (
        input  req_valid, req_op, req_src0, req_src1, req_rd, fpu_result, fpu_fin, wb_ready,
        output req_ready, fpu_src0, fpu_src1, fpu_op, wb_valid, wb_data, wb_rd, wb_int,
               busy, err
    );

    modport master (
        output req_valid, req_op, req_src0, req_src1, req_rd, fpu_result, fpu_fin, wb_ready,
        input  req_ready, fpu_src0, fpu_src1, fpu_op, wb_valid, wb_data, wb_rd, wb_int,
               busy, err
    );

endinterface

// File: rtl/fpu_issue_wdt.sv
// EXEC-cycle watchdog counter; instantiated only when FPU_ISSUE_WATCHDOG_EN is defined.
module fpu_issue_wdt #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic start,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q;

    // Asserted during the TIMEOUT-th counted cycle, so the exit happens on that cycle's edge.
    assign expired = (cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (start && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/fpu_issue.sv
// Single-outstanding FPU issue sequencer: IDLE -> EXEC (wait fpu_fin) -> WB (wait wb_ready).
// Optional EXEC watchdog enabled by FPU_ISSUE_WATCHDOG_EN.
module fpu_issue
    import fpu_pkg::*;
#(
    parameter logic [3:0]  NOP_OP  = OpNop,
    parameter int unsigned TIMEOUT = 16
) (
    input logic        clk,
    input logic        rstn,
    fpu_issue_if.slave bus
);

    fpu_issue_state_t state_q, state_d;

    logic [3:0]  op_q;
    logic [31:0] src0_q;
    logic [31:0] src1_q;
    logic [31:0] data_q;
    logic [4:0]  rd_q;
    logic        int_q;
    logic        accept;
    logic        capture;
    logic        timeout;

    assign accept  = (state_q == StIdle) && bus.req_valid;
    assign capture = (state_q == StExec) && bus.fpu_fin;

`ifdef FPU_ISSUE_WATCHDOG_EN
    logic expired;
    logic err_q;

    fpu_issue_wdt #(
        .TIMEOUT(TIMEOUT)
    ) u_wdt (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (accept),
        .start  (state_q == StExec),
        .expired(expired)
    );

    // A fin arriving on the expiry cycle still wins.
    assign timeout = (state_q == StExec) && !bus.fpu_fin && expired;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign timeout = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.req_valid) state_d = StExec;
            StExec:  if (bus.fpu_fin || timeout) state_d = StWb;
            StWb:    if (bus.wb_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q   <= '0;
            src0_q <= '0;
            src1_q <= '0;
            rd_q   <= '0;
            int_q  <= 1'b0;
            data_q <= '0;
        end else begin
            if (accept) begin
                op_q   <= bus.req_op;
                src0_q <= bus.req_src0;
                src1_q <= bus.req_src1;
                rd_q   <= bus.req_rd;
                int_q  <= is_int_dest(bus.req_op);
            end
            if (capture) begin
                data_q <= bus.fpu_result;
            end else if (timeout) begin
                data_q <= '0;
            end
        end
    end

    // Outside EXEC the FPU sees NOP so its multi-cycle counter stays idle.
    assign bus.fpu_op    = (state_q == StExec) ? op_q : NOP_OP;
    assign bus.fpu_src0  = src0_q;
    assign bus.fpu_src1  = src1_q;
    assign bus.req_ready = (state_q == StIdle);
    assign bus.wb_valid  = (state_q == StWb);
    assign bus.busy      = (state_q != StIdle);
    assign bus.wb_data   = data_q;
    assign bus.wb_rd     = rd_q;
    assign bus.wb_int    = int_q;

endmodule

// File: doc/fpu_issue.md
# fpu_issue

Core-side issue/sequencer for the floating-point unit. Accepts one FP operation at a time from decode over a valid/ready handshake and holds operands and opcode stable on the FPU input bus. Waits for the FPU `fin` strobe, captures the result, and presents it to register-file writeback over a second valid/ready handshake. It is the initiator end of the FPU `src0/src1/fpuop/result/fin` interface.

## Interface
- `NOP_OP`, default 4'hF: opcode driven to the FPU when idle. It is not a multi-cycle code, so the FPU's cycle counter never starts.
- `TIMEOUT`, default 16: maximum EXEC cycles before the watchdog fires. Used only with the watchdog macro.
- `clk` in 1: single clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: decode offers an operation.
- `req_ready` out 1: block accepts an operation.
- `req_op` in 4: FPU opcode. 0 fadd, 1 fsub, 2 fmul, 3 fdiv, 4 fsqrt, 5–7 fsgnj/n/x, 8 feq, 9 fle, 10 flt.
- `req_src0` in 32: first operand.
- `req_src1` in 32: second operand.
- `req_rd` in 5: destination register.
- `fpu_src0` out 32: operand bus to the FPU.
- `fpu_src1` out 32: operand bus to the FPU.
- `fpu_op` out 4: opcode to the FPU.
- `fpu_result` in 32: FPU result.
- `fpu_fin` in 1: FPU result valid, combinational from the FPU.
- `wb_valid` out 1: writeback offered.
- `wb_ready` in 1: writeback accepted.
- `wb_data` out 32: captured result.
- `wb_rd` out 5: destination register.
- `wb_int` out 1: destination is the integer register file. Set for ops 8–10.
- `busy` out 1: high whenever the state is not IDLE.
- `err` out 1: sticky watchdog error.

## Operation
- Three states: IDLE, EXEC, WB.
- **IDLE**
  - `req_ready=1`, `fpu_op=NOP_OP`.
  - On `req_valid`: latch op, src0, src1 and rd into registers, compute `wb_int`, go to EXEC.
- **EXEC**
  - `fpu_op`, `fpu_src0` and `fpu_src1` come from the latched registers and stay stable every cycle.
  - On a cycle with `fpu_fin=1`: capture `fpu_result` into `wb_data`, go to WB.
- **WB**
  - `wb_valid=1`, `fpu_op=NOP_OP`. The FPU counter has already returned to 0 after the `fin` cycle, so it stays idle.
  - Hold `wb_data`, `wb_rd` and `wb_int` stable until `wb_valid & wb_ready`, then go to IDLE.
- `req_ready=0` in EXEC and WB. There is no overlap; at most one operation is in flight.
- Ops 11–15 are passed through unchanged. The FPU returns `fin=1` and result 0, so they complete in one EXEC cycle with `wb_data=0`.
- Operand buses are don't-care in IDLE and WB; they hold their last latched value.
- Reset values:
  - state IDLE
  - `req_ready=1`, `wb_valid=0`, `busy=0`, `err=0`
  - `fpu_op=NOP_OP`
  - `wb_data`, `wb_rd`, `wb_int`, `fpu_src0`, `fpu_src1` all 0.
- Reset asserted in the middle of an operation aborts it, and no writeback is produced.
  - The FPU resets synchronously, so `rstn` must be held low for at least 2 `clk` edges.

## Timing
- Cycle 0 is the accept edge (`req_valid & req_ready`). EXEC starts in cycle 1.
- Writeback latency, measured from the accept edge to `wb_valid` rising:
  - ops 5–15: 2 cycles
  - fadd, fsub, fmul: 5 cycles (fin on the 4th EXEC cycle)
  - fsqrt: 10 cycles
  - fdiv: 12 cycles
- The block does not hard-code these latencies; it relies solely on `fpu_fin`.
- Next accept is possible one cycle after the writeback handshake.

## Configuration
- Macro: `FPU_ISSUE_WATCHDOG_EN`.
- Defined:
  - An EXEC cycle counter is cleared on entry to EXEC.
  - If it reaches `TIMEOUT` with no `fpu_fin`, the block goes to WB with `wb_data=0` and sets `err`.
  - `err` remains set until reset.
- Undefined:
  - There is no counter.
  - `err` is tied to 0.
  - EXEC waits indefinitely for `fpu_fin`.

## Structure
- Package `fpu_pkg` holds:
  - the `fpu_op_t` opcode enum (0–10 plus NOP)
  - the `fpu_issue_state_t` enum (IDLE/EXEC/WB)
  - helper function `is_int_dest(op)`.
- One sub-module, `fpu_issue_wdt`: the timeout counter with start/clear/expired signals. It is instantiated only under `FPU_ISSUE_WATCHDOG_EN`.

## Test plan
- **fadd:** src0=0x3F800000, src1=0x40000000, real `fpu` attached.
  - `wb_valid` 5 cycles after accept, `wb_data=0x40400000`, `wb_int=0`.
- **fle:** op=9, 1.0 vs 2.0.
  - `wb_valid` at cycle 2, `wb_data=1`, `wb_int=1`, `wb_rd` equal to the request rd.
- **fdiv:** 0x40C00000 / 0x40000000.
  - `wb_data=0x40400000` at cycle 12.
  - `fpu_op=3` stable through all EXEC cycles, then NOP in WB.
- **Backpressure:** `wb_ready` held low for 3 cycles, with `req_valid` high the whole time.
  - `wb_*` stable, `req_ready=0`.
  - The next request is accepted the cycle after the handshake.
- **Reset:** `rstn` pulsed low for 2 cycles during EXEC of fdiv.
  - Outputs return to reset values, with no writeback.
  - A following fmul completes correctly in 5 cycles.
- **Watchdog** (`FPU_ISSUE_WATCHDOG_EN`, `TIMEOUT=16`): FPU stub holds `fin=0`.
  - `wb_valid` at cycle 17, `wb_data=0`, `err=1`, and `err` stays set.
